clk_sel_sequencer: RTL and testbench

Control stage that sits directly upstream of the derived-clock select/data block and drives its 4-bit clock select and 32-bit data input. It sequences every clock-source change: freezes the data presented downstream, drains for a fixed window, updates the select, waits for the new clock to settle, then acknowledges. Runs entirely on the undivided source clock.

---
 rtl/clk_sel_sequencer.sv | 158 +++++++++++++++
 tb/tb_clk_sel_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_sel_sequencer.sv
// clk_sel_sequencer
//   Sequences every change of the downstream clock select: freezes data_out,
//   drains for DRAIN_CYCLES, updates sel, settles for SETTLE_CYCLES, then
//   pulses ack. Everything runs on clk_in.
//   Optional feature macro: CLK_SEL_SWCNT_EN adds the 16-bit saturating
//   sw_count output counting completed non-NOP switches.
module clk_sel_sequencer #(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned DRAIN_CYCLES  = 4,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter logic [3:0]  RESET_SEL     = 4'h0
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              req,
  input  logic [3:0]        req_sel,
  output logic              ack,
  output logic              busy,
  output logic              req_drop,
  output logic [3:0]        sel,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_hold
`ifdef CLK_SEL_SWCNT_EN
  ,
  output logic [15:0]       sw_count
`endif
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] DRAIN  = 3'd1;
  localparam logic [2:0] SWITCH = 3'd2;
  localparam logic [2:0] SETTLE = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  // Counter reload values; the counter expires on 0, so N cycles load N-1.
  localparam logic [7:0] DRAIN_LOAD  = 8'(DRAIN_CYCLES - 1);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  logic [2:0]        state_q,  state_d;
  logic [7:0]        cnt_q,    cnt_d;
  logic [3:0]        target_q, target_d;
  logic [3:0]        sel_q,    sel_d;
  logic [DATA_W-1:0] data_q,   data_d;
  logic              drop_q,   drop_d;
  logic              nop_q,    nop_d;

  // Next-state, counter, select and data-capture logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    sel_d    = sel_q;
    data_d   = data_q;
    nop_d    = nop_q;
    drop_d   = req && (state_q != IDLE);

    if (state_q == IDLE) begin
      data_d = data_in;
    end

    case (state_q)
      IDLE: begin
        if (req) begin
          if (req_sel != sel_q) begin
            target_d = req_sel;
            cnt_d    = DRAIN_LOAD;
            nop_d    = 1'b0;
            state_d  = DRAIN;
          end else begin
            nop_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          state_d = SWITCH;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      SWITCH: begin
        sel_d   = target_q;
        cnt_d   = SETTLE_LOAD;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state registers with asynchronous reset.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      target_q <= '0;
      sel_q    <= RESET_SEL;
      data_q   <= '0;
      drop_q   <= 1'b0;
      nop_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      sel_q    <= sel_d;
      data_q   <= data_d;
      drop_q   <= drop_d;
      nop_q    <= nop_d;
    end
  end

  // Status flags decoded from state; none depends combinationally on inputs.
  always_comb begin
    ack       = (state_q == DONE);
    busy      = (state_q != IDLE);
    data_hold = (state_q != IDLE);
    req_drop  = drop_q;
    sel       = sel_q;
    data_out  = data_q;
  end

`ifdef CLK_SEL_SWCNT_EN
  logic [15:0] swc_q, swc_d;

  // Saturating count of completed real switches, bumped while in DONE.
  always_comb begin
    swc_d = swc_q;
    if ((state_q == DONE) && !nop_q && (swc_q != '1)) begin
      swc_d = swc_q + 16'd1;
    end
  end

  // Switch counter register; only rst clears it.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      swc_q <= '0;
    end else begin
      swc_q <= swc_d;
    end
  end

  assign sw_count = swc_q;
`endif

endmodule

// File: tb/tb_clk_sel_sequencer.sv
// Bench for clk_sel_sequencer: three instances with different drain/settle
// lengths and reset selects, driven by shared stimulus and compared every
// cycle against a transaction-level model that tracks cycles since accept.
module tb_clk_sel_sequencer;

  localparam int NI = 3;
  localparam int unsigned DP [NI] = '{4, 1, 255};
  localparam int unsigned SP [NI] = '{8, 1, 3};
  localparam logic [3:0]  RS [NI] = '{4'h0, 4'h3, 4'hC};

  logic        clk_in  = 1'b0;
  logic        rst     = 1'b1;
  logic        req     = 1'b0;
  logic [3:0]  req_sel = '0;
  logic [31:0] data_in = '0;

  logic [NI-1:0] ack_v, busy_v, drop_v, hold_v;
  logic [3:0]    sel_v  [NI];
  logic [31:0]   dout_v [NI];
`ifdef CLK_SEL_SWCNT_EN
  logic [15:0]   swc_v  [NI];
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk_in = ~clk_in;

  clk_sel_sequencer #(.DATA_W(32), .DRAIN_CYCLES(4), .SETTLE_CYCLES(8), .RESET_SEL(4'h0)) u0 (
    .clk_in(clk_in), .rst(rst), .req(req), .req_sel(req_sel),
    .ack(ack_v[0]), .busy(busy_v[0]), .req_drop(drop_v[0]), .sel(sel_v[0]),
    .data_in(data_in), .data_out(dout_v[0]), .data_hold(hold_v[0])
`ifdef CLK_SEL_SWCNT_EN
    , .sw_count(swc_v[0])
`endif
  );

  clk_sel_sequencer #(.DATA_W(32), .DRAIN_CYCLES(1), .SETTLE_CYCLES(1), .RESET_SEL(4'h3)) u1 (
    .clk_in(clk_in), .rst(rst), .req(req), .req_sel(req_sel),
    .ack(ack_v[1]), .busy(busy_v[1]), .req_drop(drop_v[1]), .sel(sel_v[1]),
    .data_in(data_in), .data_out(dout_v[1]), .data_hold(hold_v[1])
`ifdef CLK_SEL_SWCNT_EN
    , .sw_count(swc_v[1])
`endif
  );

  clk_sel_sequencer #(.DATA_W(32), .DRAIN_CYCLES(255), .SETTLE_CYCLES(3), .RESET_SEL(4'hC)) u2 (
    .clk_in(clk_in), .rst(rst), .req(req), .req_sel(req_sel),
    .ack(ack_v[2]), .busy(busy_v[2]), .req_drop(drop_v[2]), .sel(sel_v[2]),
    .data_in(data_in), .data_out(dout_v[2]), .data_hold(hold_v[2])
`ifdef CLK_SEL_SWCNT_EN
    , .sw_count(swc_v[2])
`endif
  );

  // Model: a sequence is "active" from its accepting edge; m_n counts edges
  // since then. Real switch: sel updates at edge D+1, ends at edge D+S+2.
  // NOP: ends at edge 1.
  bit          m_act  [NI];
  int unsigned m_n    [NI];
  bit          m_nop  [NI];
  logic [3:0]  m_sel  [NI];
  logic [3:0]  m_tgt  [NI];
  logic [31:0] m_dout [NI];
  bit          m_drop [NI];
  int unsigned m_cnt  [NI];

  always @(posedge clk_in or posedge rst) begin
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        m_act[i]  = 1'b0;
        m_n[i]    = 0;
        m_nop[i]  = 1'b0;
        m_sel[i]  = RS[i];
        m_tgt[i]  = '0;
        m_dout[i] = '0;
        m_drop[i] = 1'b0;
        m_cnt[i]  = 0;
      end else if (!m_act[i]) begin
        m_drop[i] = 1'b0;
        m_dout[i] = data_in;
        if (req) begin
          m_act[i] = 1'b1;
          m_n[i]   = 0;
          m_nop[i] = (req_sel == m_sel[i]);
          if (!m_nop[i]) m_tgt[i] = req_sel;
        end
      end else begin
        m_drop[i] = req;
        m_n[i]    = m_n[i] + 1;
        if (!m_nop[i] && m_n[i] == DP[i] + 1) m_sel[i] = m_tgt[i];
        if (m_nop[i] ? (m_n[i] == 1) : (m_n[i] == DP[i] + SP[i] + 2)) begin
          m_act[i] = 1'b0;
          if (!m_nop[i] && m_cnt[i] != 65535) m_cnt[i] = m_cnt[i] + 1;
        end
      end
    end
  end

  function automatic logic exp_ack(input int i);
    return m_act[i] && (m_nop[i] ? (m_n[i] == 0) : (m_n[i] == DP[i] + SP[i] + 1));
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %h expected %h at %0t", nm, i, act, exp, $time);
  endtask

  // Advance to the next falling edge and compare every instance to the model.
  task automatic tick();
    @(negedge clk_in);
    for (int i = 0; i < NI; i++) begin
      chk("ack",      i, 32'(ack_v[i]),  32'(exp_ack(i)));
      chk("busy",     i, 32'(busy_v[i]), 32'(m_act[i]));
      chk("hold",     i, 32'(hold_v[i]), 32'(m_act[i]));
      chk("req_drop", i, 32'(drop_v[i]), 32'(m_drop[i]));
      chk("sel",      i, 32'(sel_v[i]),  32'(m_sel[i]));
      chk("data_out", i, dout_v[i],      m_dout[i]);
`ifdef CLK_SEL_SWCNT_EN
      chk("sw_count", i, 32'(swc_v[i]),  32'(m_cnt[i]));
`endif
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // Reset, then idle: nothing may move.
    tick();
    chk("lit_rst_sel", 0, 32'(sel_v[0]), 32'h0);
    chk("lit_rst_sel", 1, 32'(sel_v[1]), 32'h3);
    chk("lit_rst_dout", 0, dout_v[0], 32'h0);
    chk("lit_rst_busy", 0, 32'(busy_v[0]), 32'h0);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("lit_idle_sel", 0, 32'(sel_v[0]), 32'h0);
      chk("lit_idle_ack", 0, 32'(ack_v[0]), 32'h0);
    end

    // Real switch to 5 with a dropped request at edge 3, then a request held
    // across the return-to-IDLE edge (dropped) and accepted next edge as NOP.
    data_in = 32'hA5A5_0000;
    req     = 1'b1;
    req_sel = 4'h5;
    for (int k = 0; k <= 16; k++) begin
      tick();
      chk("lit_sel",  0, 32'(sel_v[0]),  (k >= 5) ? 32'h5 : 32'h0);
      chk("lit_ack",  0, 32'(ack_v[0]),  32'((k == 13) || (k == 15)));
      chk("lit_busy", 0, 32'(busy_v[0]), 32'((k <= 13) || (k == 15)));
      chk("lit_drop", 0, 32'(drop_v[0]), 32'((k == 3) || (k == 14)));
      chk("lit_dout", 0, dout_v[0], (k <= 14) ? 32'hA5A5_0000 : 32'h1000_000E);
      data_in = 32'h1000_0000 + 32'(k);
      case (k)
        0:  req = 1'b0;
        2:  begin req = 1'b1; req_sel = 4'hA; end
        3:  req = 1'b0;
        13: begin req = 1'b1; req_sel = 4'h5; end
        15: req = 1'b0;
        default: ;
      endcase
    end

    // Reset pulsed mid-cycle during SETTLE: no ack, sel back to reset value.
    req     = 1'b1;
    req_sel = 4'h9;
    for (int k = 0; k <= 8; k++) begin
      tick();
      if (k == 0) req = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("lit_mid_rst_sel",  0, 32'(sel_v[0]),  32'h0);
    chk("lit_mid_rst_busy", 0, 32'(busy_v[0]), 32'h0);
    chk("lit_mid_rst_ack",  0, 32'(ack_v[0]),  32'h0);
    chk("lit_mid_rst_dout", 0, dout_v[0],      32'h0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("lit_post_rst_ack", 0, 32'(ack_v[0]), 32'h0);
    end
    req     = 1'b1;
    req_sel = 4'h7;
    for (int k = 0; k <= 14; k++) begin
      tick();
      if (k == 0) req = 1'b0;
      chk("lit_re_sel", 0, 32'(sel_v[0]), (k >= 5) ? 32'h7 : 32'h0);
      chk("lit_re_ack", 0, 32'(ack_v[0]), 32'(k == 13));
    end

    // Randomized traffic, including NOPs, drops and occasional resets.
    for (int k = 0; k < 3000; k++) begin
      tick();
      rst     = ($urandom_range(0, 499) == 0);
      req     = ($urandom_range(0, 5) == 0);
      req_sel = ($urandom_range(0, 3) == 0) ? m_sel[$urandom_range(0, NI - 1)]
                                            : 4'($urandom_range(0, 15));
      data_in = $urandom;
    end
    rst = 1'b0;
    req = 1'b0;
    for (int k = 0; k < 5; k++) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
